lpm_tbl_ctrl: RTL and testbench



---
 rtl/lpm_tbl_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_lpm_tbl_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpm_tbl_ctrl.sv
// Sequencing controller for the LPM route table port: serialises host reads/writes,
// runs a hardware flush of every entry, and bounds each table transaction with an ack timeout.
module lpm_tbl_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_WIDTH = 5,
  parameter int TBL_DEPTH = 32,
  parameter int ACK_TIMEOUT = 15,
  parameter logic [4*C_S_AXI_DATA_WIDTH-1:0] FLUSH_VALUE = {(4*C_S_AXI_DATA_WIDTH){1'b1}}
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESETN,
  input  logic                            host_rd_req,
  input  logic                            host_wr_req,
  input  logic [TBL_ADDR_WIDTH-1:0]       host_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] host_wr_data,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] host_rd_data,
  output logic                            host_done,
  output logic                            host_err,
  output logic                            host_busy,
  input  logic                            flush_start,
  output logic                            flush_busy,
  output logic                            flush_done,
  output logic                            tbl_rd_req,
  output logic                            tbl_wr_req,
  output logic [TBL_ADDR_WIDTH-1:0]       tbl_rd_addr,
  output logic [TBL_ADDR_WIDTH-1:0]       tbl_wr_addr,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                            tbl_rd_ack,
  input  logic                            tbl_wr_ack,
  output logic [31:0]                     timeout_count
);

  localparam int EW = 4 * C_S_AXI_DATA_WIDTH;
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TBL_ADDR_WIDTH-1:0] CNT_LAST = TBL_ADDR_WIDTH'(TBL_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT     = 3'd2,
    FL_ISSUE = 3'd3,
    FL_WAIT  = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic                      op_wr_q, op_wr_d;
  logic [TBL_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [EW-1:0]             data_q, data_d;
  logic [EW-1:0]             rd_data_q, rd_data_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [TBL_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                      adv_q, adv_d;
  logic                      pend_q, pend_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      fdone_q, fdone_d;
  logic [31:0]               tocnt_q, tocnt_d;

  logic in_flush;
  logic host_acc;
  logic fl_acc;
  logic ack_match;
  logic to_hit;

  assign in_flush   = (state_q == FL_ISSUE) || (state_q == FL_WAIT);
  assign flush_busy = pend_q || in_flush;
  assign host_busy  = (state_q == ISSUE) || (state_q == WAIT) || done_q || flush_busy;
  assign host_acc   = (state_q == IDLE) && !host_busy && (host_wr_req || host_rd_req);
  assign fl_acc     = flush_start && !flush_busy;
  assign ack_match  = op_wr_q ? tbl_wr_ack : tbl_rd_ack;

  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    adv_d     = adv_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fdone_d   = 1'b0;
    to_hit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_acc) begin
          // A simultaneous write and read collapses to the write.
          op_wr_d = host_wr_req;
          addr_d  = host_addr;
          data_d  = host_wr_data;
          state_d = ISSUE;
          if (fl_acc) pend_d = 1'b1;
        end else if (fl_acc || pend_q) begin
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = FL_ISSUE;
        end
      end
      ISSUE: begin
        if (fl_acc) pend_d = 1'b1;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fl_acc) pend_d = 1'b1;
        if (ack_match) begin
          if (!op_wr_q) rd_data_d = tbl_rd_data;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timer_q == TMR_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          to_hit  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FL_ISSUE: begin
        timer_d = '0;
        adv_d   = 1'b0;
        state_d = FL_WAIT;
      end
      FL_WAIT: begin
        // adv_q marks the step cycle after an entry resolved (ack or timeout).
        if (adv_q) begin
          adv_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            fdone_d = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + TBL_ADDR_WIDTH'(1);
            state_d = FL_ISSUE;
          end
        end else if (tbl_wr_ack) begin
          adv_d = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          adv_d  = 1'b1;
          to_hit = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    tocnt_d = (to_hit && (tocnt_q != 32'hFFFF_FFFF)) ? tocnt_q + 32'd1 : tocnt_q;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q   <= IDLE;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      adv_q     <= 1'b0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      fdone_q   <= 1'b0;
      tocnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      adv_q     <= adv_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      err_q     <= err_d;
      fdone_q   <= fdone_d;
      tocnt_q   <= tocnt_d;
    end
  end

  assign host_rd_data  = rd_data_q;
  assign host_done     = done_q;
  assign host_err      = err_q;
  assign flush_done    = fdone_q;
  assign timeout_count = tocnt_q;
  assign tbl_rd_req    = (state_q == ISSUE) && !op_wr_q;
  assign tbl_wr_req    = ((state_q == ISSUE) && op_wr_q) || (state_q == FL_ISSUE);
  assign tbl_rd_addr   = addr_q;
  assign tbl_wr_addr   = in_flush ? cnt_q : addr_q;
  assign tbl_wr_data   = in_flush ? FLUSH_VALUE : data_q;

endmodule

// File: tb/tb_lpm_tbl_ctrl.sv
// Bench for lpm_tbl_ctrl: a responding table model plus a behavioural reference of table
// contents, read data and timeout totals; one task per scenario.
module tb_lpm_tbl_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         host_rd_req, host_wr_req, flush_start;
  logic [4:0]   host_addr;
  logic [127:0] host_wr_data;
  logic [127:0] host_rd_data;
  logic         host_done, host_err, host_busy, flush_busy, flush_done;
  logic         tbl_rd_req, tbl_wr_req;
  logic [4:0]   tbl_rd_addr, tbl_wr_addr;
  logic [127:0] tbl_wr_data, tbl_rd_data;
  logic         tbl_rd_ack, tbl_wr_ack;
  logic [31:0]  timeout_count;

  int total = 0;
  int bad = 0;

  logic [127:0] ref_mem [32];
  logic [127:0] last_rd;
  int           exp_to;
  logic         ack_en;
  logic [127:0] tbl_mem [32];

  localparam logic [127:0] ONES = {128{1'b1}};

  always #5 clk = ~clk;

  lpm_tbl_ctrl dut (
    .AXI_ACLK(clk), .AXI_RESETN(rst_n),
    .host_rd_req(host_rd_req), .host_wr_req(host_wr_req), .host_addr(host_addr),
    .host_wr_data(host_wr_data), .host_rd_data(host_rd_data), .host_done(host_done),
    .host_err(host_err), .host_busy(host_busy), .flush_start(flush_start),
    .flush_busy(flush_busy), .flush_done(flush_done), .tbl_rd_req(tbl_rd_req),
    .tbl_wr_req(tbl_wr_req), .tbl_rd_addr(tbl_rd_addr), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data), .tbl_rd_data(tbl_rd_data), .tbl_rd_ack(tbl_rd_ack),
    .tbl_wr_ack(tbl_wr_ack), .timeout_count(timeout_count)
  );

  // Table model: acks one cycle after a strobe; stays silent when ack_en is low.
  always @(posedge clk) begin
    tbl_rd_ack <= 1'b0;
    tbl_wr_ack <= 1'b0;
    if (ack_en) begin
      if (tbl_wr_req) begin
        tbl_mem[tbl_wr_addr] <= tbl_wr_data;
        tbl_wr_ack <= 1'b1;
      end
      if (tbl_rd_req) begin
        tbl_rd_data <= tbl_mem[tbl_rd_addr];
        tbl_rd_ack <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one host request (cycle 0) and observes the cycles up to host_done.
  task automatic host_op(input logic wr, input logic rd, input logic [4:0] a,
                         input logic [127:0] d, output int done_cyc, output int strobe_cyc,
                         output int n_wr, output int n_rd, output logic err,
                         output logic [127:0] rdata, output int busy_low);
    host_wr_req = wr; host_rd_req = rd; host_addr = a; host_wr_data = d;
    done_cyc = -1; strobe_cyc = -1; n_wr = 0; n_rd = 0; err = 1'b0; rdata = '0; busy_low = 0;
    tick();
    host_wr_req = 1'b0; host_rd_req = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (tbl_wr_req) n_wr++;
      if (tbl_rd_req) n_rd++;
      if ((tbl_wr_req || tbl_rd_req) && strobe_cyc < 0) strobe_cyc = c;
      if (!host_busy) busy_low++;
      if (host_done) begin
        done_cyc = c; err = host_err; rdata = host_rd_data;
        break;
      end
      tick();
    end
    tick();
  endtask

  // Pulses flush_start and follows the walk until flush_done.
  task automatic run_flush(output int fs, output int fd, output int nw, output int nbad,
                           output int first_addr);
    int e;
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    fs = -1; fd = -1; nw = 0; nbad = 0; first_addr = -1; e = 0;
    for (int c = 1; c <= 2000; c++) begin
      if (tbl_wr_req) begin
        if (fs < 0) begin fs = c; first_addr = int'(tbl_wr_addr); end
        if (int'(tbl_wr_addr) != e || tbl_wr_data !== ONES) nbad++;
        e++; nw++;
      end
      if (flush_done) begin fd = c; break; end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; host_rd_req = 0; host_wr_req = 0; flush_start = 0;
    host_addr = '0; host_wr_data = '0; ack_en = 1'b1;
    last_rd = '0; exp_to = 0;
    repeat (3) tick();
    total++;
    if ({host_rd_data, host_done, host_err, host_busy, flush_busy, flush_done, tbl_rd_req,
         tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data, timeout_count} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs rd_data=%h to=%0d busy=%b",
                      host_rd_data, timeout_count, host_busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int dc, sc, nw, nr, bl; logic er; logic [127:0] rd;
    logic [127:0] v = 128'h0000_0002_0A00_0001_FFFF_FF00_0A00_0000;
    host_op(1'b1, 1'b0, 5'd3, v, dc, sc, nw, nr, er, rd, bl);
    ref_mem[3] = v;
    total++; if (sc !== 1 || nw !== 1 || nr !== 0) begin
      bad++; $display("FAIL wr_strobe: cyc=%0d wr=%0d rd=%0d want 1/1/0", sc, nw, nr); end
    total++; if (dc !== 3 || er !== 1'b0) begin
      bad++; $display("FAIL wr_done: cyc=%0d err=%b want 3/0", dc, er); end
    total++; if (bl !== 0) begin
      bad++; $display("FAIL wr_busy: busy low %0d cycles want 0", bl); end
    host_op(1'b0, 1'b1, 5'd3, '0, dc, sc, nw, nr, er, rd, bl);
    last_rd = ref_mem[3];
    total++; if (dc !== 3 || sc !== 1 || nr !== 1 || nw !== 0) begin
      bad++; $display("FAIL rd_timing: done=%0d strobe=%0d rd=%0d wr=%0d", dc, sc, nr, nw); end
    total++; if (rd !== ref_mem[3] || er !== 1'b0) begin
      bad++; $display("FAIL rd_data: got %h err=%b want %h", rd, er, ref_mem[3]); end
  endtask

  task automatic test_both_req();
    int dc, sc, nw, nr, bl, extra; logic er; logic [127:0] rd;
    logic [127:0] v = rnd128();
    host_op(1'b1, 1'b1, 5'd7, v, dc, sc, nw, nr, er, rd, bl);
    ref_mem[7] = v;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (host_done) extra++;
      tick();
    end
    total++; if (nw !== 1 || nr !== 0 || dc !== 3 || extra !== 0) begin
      bad++; $display("FAIL both_req: wr=%0d rd=%0d done=%0d extra=%0d want 1/0/3/0",
                      nw, nr, dc, extra); end
    host_op(1'b0, 1'b1, 5'd7, '0, dc, sc, nw, nr, er, rd, bl);
    last_rd = ref_mem[7];
    total++; if (rd !== v) begin
      bad++; $display("FAIL both_req_readback: got %h want %h", rd, v); end
  endtask

  task automatic test_random();
    int dc, sc, nw, nr, bl, lat_bad, data_bad; logic er; logic [127:0] rd, v;
    logic [4:0] a;
    lat_bad = 0; data_bad = 0;
    for (int i = 0; i < 32; i++) begin
      v = rnd128(); a = 5'(i);
      host_op(1'b1, 1'b0, a, v, dc, sc, nw, nr, er, rd, bl);
      ref_mem[i] = v;
      if (dc != 3 || er) lat_bad++;
    end
    for (int i = 0; i < 40; i++) begin
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        v = rnd128();
        host_op(1'b1, 1'b0, a, v, dc, sc, nw, nr, er, rd, bl);
        ref_mem[a] = v;
        if (dc != 3 || er || nw != 1) lat_bad++;
      end else begin
        host_op(1'b0, 1'b1, a, '0, dc, sc, nw, nr, er, rd, bl);
        last_rd = ref_mem[a];
        if (dc != 3 || er || nr != 1) lat_bad++;
        if (rd !== ref_mem[a]) data_bad++;
      end
    end
    total++; if (lat_bad !== 0) begin
      bad++; $display("FAIL random_latency: %0d ops off want 0", lat_bad); end
    total++; if (data_bad !== 0) begin
      bad++; $display("FAIL random_rdata: %0d reads wrong want 0", data_bad); end
  endtask

  task automatic test_flush();
    int dc, sc, nw, nr, bl, fs, fd, fw, fb, fa; logic er; logic [127:0] rd;
    host_op(1'b1, 1'b0, 5'd0, rnd128(), dc, sc, nw, nr, er, rd, bl);
    host_op(1'b1, 1'b0, 5'd31, rnd128(), dc, sc, nw, nr, er, rd, bl);
    run_flush(fs, fd, fw, fb, fa);
    for (int i = 0; i < 32; i++) ref_mem[i] = ONES;
    total++; if (fw !== 32 || fb !== 0) begin
      bad++; $display("FAIL flush_writes: count=%0d badaddr/data=%0d want 32/0", fw, fb); end
    total++; if (fs < 0 || fd < 0 || fd - fs !== 96) begin
      bad++; $display("FAIL flush_timing: first=%0d done=%0d want done-first=96", fs, fd); end
    host_op(1'b0, 1'b1, 5'd31, '0, dc, sc, nw, nr, er, rd, bl);
    last_rd = ref_mem[31];
    total++; if (rd !== ONES) begin
      bad++; $display("FAIL flush_readback: got %h want all ones", rd); end
  endtask

  task automatic test_flush_with_host();
    int hd, fs, fd, busy_low; logic [127:0] rd;
    host_rd_req = 1'b1; host_addr = 5'd5; flush_start = 1'b1;
    tick();
    host_rd_req = 1'b0; flush_start = 1'b0;
    hd = -1; fs = -1; fd = -1; busy_low = 0; rd = '0;
    for (int c = 1; c <= 400; c++) begin
      if (flush_done) begin fd = c; break; end
      if (!host_busy) busy_low++;
      if (host_done) begin hd = c; rd = host_rd_data; end
      if (hd >= 0 && c > hd && tbl_wr_req && fs < 0) fs = c;
      tick();
    end
    tick();
    last_rd = ref_mem[5];
    total++; if (hd !== 3 || rd !== ref_mem[5]) begin
      bad++; $display("FAIL flush_host_read: done=%0d data=%h want 3/%h", hd, rd, ref_mem[5]); end
    total++; if (fs !== hd + 1 || fd < 0) begin
      bad++; $display("FAIL flush_after_host: flush=%0d done=%0d host_done=%0d", fs, fd, hd); end
    total++; if (busy_low !== 0) begin
      bad++; $display("FAIL flush_host_busy: busy low %0d cycles want 0", busy_low); end
  endtask

  task automatic test_timeout();
    int dc, sc, nw, nr, bl, fs, fd, fw, fb, fa; logic er; logic [127:0] rd;
    ack_en = 1'b0;
    host_op(1'b0, 1'b1, 5'd2, '0, dc, sc, nw, nr, er, rd, bl);
    exp_to = exp_to + 1;
    total++; if (dc !== 1 + 15 + 1 || er !== 1'b1) begin
      bad++; $display("FAIL timeout_done: cyc=%0d err=%b want 17/1", dc, er); end
    total++; if (rd !== last_rd) begin
      bad++; $display("FAIL timeout_rdata: got %h want %h", rd, last_rd); end
    total++; if (timeout_count !== 32'(exp_to)) begin
      bad++; $display("FAIL timeout_count_host: got %0d want %0d", timeout_count, exp_to); end
    run_flush(fs, fd, fw, fb, fa);
    exp_to = exp_to + 32;
    total++; if (fd < 0 || fw !== 32) begin
      bad++; $display("FAIL timeout_flush_done: done=%0d writes=%0d want pulse/32", fd, fw); end
    total++; if (timeout_count !== 32'(exp_to)) begin
      bad++; $display("FAIL timeout_count_flush: got %0d want %0d", timeout_count, exp_to); end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid_flush();
    int hit, n_fd, n_wr, fs, fd, fw, fb, fa;
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      if (tbl_wr_req && tbl_wr_addr == 5'd10) begin hit = 1; break; end
      tick();
    end
    total++; if (hit !== 1) begin
      bad++; $display("FAIL midflush_reach10: entry 10 strobe seen=%0d want 1", hit); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({host_rd_data, host_done, host_err, host_busy, flush_busy, flush_done, tbl_rd_req,
         tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data, timeout_count} !== '0) begin
      bad++; $display("FAIL midflush_async_reset: outputs nonzero wr_req=%b busy=%b to=%0d",
                      tbl_wr_req, flush_busy, timeout_count); end
    exp_to = 0; last_rd = '0;
    tick(); tick();
    rst_n = 1'b1;
    n_fd = 0; n_wr = 0;
    for (int c = 0; c < 150; c++) begin
      if (flush_done) n_fd++;
      if (tbl_wr_req || flush_busy) n_wr++;
      tick();
    end
    total++; if (n_fd !== 0 || n_wr !== 0) begin
      bad++; $display("FAIL midflush_no_done: done=%0d activity=%0d want 0/0", n_fd, n_wr); end
    run_flush(fs, fd, fw, fb, fa);
    total++; if (fa !== 0 || fw !== 32 || fb !== 0 || fd - fs !== 96) begin
      bad++; $display("FAIL midflush_restart: first=%0d writes=%0d bad=%0d span=%0d",
                      fa, fw, fb, fd - fs); end
    total++; if (timeout_count !== 32'(exp_to)) begin
      bad++; $display("FAIL midflush_tocount: got %0d want %0d", timeout_count, exp_to); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_both_req();
    test_random();
    test_flush();
    test_flush_with_host();
    test_timeout();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
